// File: rtl/retire_unit_pkg.sv
// Shared types and constants for the retire unit and its statistics block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package retire_unit_pkg;

    localparam int PRF_IDX  = 7;   // physical register index width (128 PRF entries)
    localparam int ROB_IDX  = 6;   // reorder buffer index width (64 entries)
    localparam int ARF_IDX  = 5;   // architectural register index width
    localparam logic [ARF_IDX-1:0] ZERO_REG = 5'd31;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2
    } retire_state_t;

    // A retiring slot updates architectural state only when it writes a
    // register other than the hardwired zero register.
    function automatic logic writes_arch(input logic wr, input logic [ARF_IDX-1:0] ardest);
        return wr && (ardest != ZERO_REG);
    endfunction

endpackage

// File: rtl/retire_unit_stats.sv
// Retirement statistics: counts retired instructions and retired mispredicts.
// Latency: counters reflect a cycle's retirements one cycle later.
// Backpressure: none; free-running counters wrap modulo 2^32.
// Ports: clk/reset (sync, active-high); pop_cnt (0..2) and mispred_cnt (0..2)
// per cycle in; stat_retired / stat_mispred running totals out.
module retire_stats
    import retire_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  pop_cnt,
    input  logic [1:0]  mispred_cnt,
    output logic [31:0] stat_retired,
    output logic [31:0] stat_mispred
);

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_retired <= '0;
            stat_mispred <= '0;
        end else begin
            stat_retired <= stat_retired + {30'd0, pop_cnt};
            stat_mispred <= stat_mispred + {30'd0, mispred_cnt};
        end
    end

endmodule

// File: rtl/retire_unit.sv
// Two-wide in-order retire unit: pops the ROB head pair, updates the arch map,
// frees old physical registers and handles mispredict flush / halt.
// Latency: rd1/rd2 combinational; all other outputs registered, one cycle after the pop.
// Backpressure: pops only ready heads; stalls completely during FLUSH and HALT.
// Ports: clk, reset (sync, active-high); hN_* ROB head/head+1 entries; rdN pop
// requests; freeN_* free-list returns; archN_* arch map writes; flush,
// redirect_pc, halted, retire_cnt; stat_retired/stat_mispred.
// Optional: define RETIRE_STATS_EN to build the statistics counters; otherwise
// the stat outputs are tied to zero.
module retire_unit
    import retire_unit_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               h1_valid,
    input  logic               h1_done,
    input  logic               h1_wr,
    input  logic [ARF_IDX-1:0] h1_ardest,
    input  logic [PRF_IDX-1:0] h1_pdest,
    input  logic [PRF_IDX-1:0] h1_pold,
    input  logic               h1_mispred,
    input  logic               h1_halt,
    input  logic [63:0]        h1_target,
    input  logic               h2_valid,
    input  logic               h2_done,
    input  logic               h2_wr,
    input  logic [ARF_IDX-1:0] h2_ardest,
    input  logic [PRF_IDX-1:0] h2_pdest,
    input  logic [PRF_IDX-1:0] h2_pold,
    input  logic               h2_mispred,
    input  logic               h2_halt,
    input  logic [63:0]        h2_target,
    output logic               rd1,
    output logic               rd2,
    output logic               free1_valid,
    output logic [PRF_IDX-1:0] free1_idx,
    output logic               free2_valid,
    output logic [PRF_IDX-1:0] free2_idx,
    output logic               arch1_en,
    output logic [ARF_IDX-1:0] arch1_idx,
    output logic [PRF_IDX-1:0] arch1_pdest,
    output logic               arch2_en,
    output logic [ARF_IDX-1:0] arch2_idx,
    output logic [PRF_IDX-1:0] arch2_pdest,
    output logic               flush,
    output logic [63:0]        redirect_pc,
    output logic               halted,
    output logic [1:0]         retire_cnt,
    output logic [31:0]        stat_retired,
    output logic [31:0]        stat_mispred
);

    retire_state_t state, state_nxt;
    logic          redirect_load;
    logic [63:0]   redirect_nxt;
    logic [1:0]    pop_cnt;

    always_ff @(posedge clk) begin
        if (reset) state <= RUN;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        rd1           = 1'b0;
        rd2           = 1'b0;
        redirect_load = 1'b0;
        redirect_nxt  = h1_target;
        case (state)
            RUN: begin
                // Pops are suppressed while reset is asserted so nothing leaves the ROB.
                rd1 = !reset && h1_valid && h1_done;
                // Head+1 never retires alongside an older mispredict or halt.
                rd2 = rd1 && h2_valid && h2_done && !h1_mispred && !h1_halt;
                // Halt outranks mispredict; the older slot is examined first.
                if (rd1 && h1_halt) begin
                    state_nxt = HALT;
                end else if (rd1 && h1_mispred) begin
                    state_nxt     = FLUSH;
                    redirect_load = 1'b1;
                end else if (rd2 && h2_halt) begin
                    state_nxt = HALT;
                end else if (rd2 && h2_mispred) begin
                    state_nxt     = FLUSH;
                    redirect_load = 1'b1;
                    redirect_nxt  = h2_target;
                end
            end
            FLUSH:   state_nxt = RUN;
            HALT:    state_nxt = HALT;
            default: state_nxt = RUN;
        endcase
    end

    assign pop_cnt = {1'b0, rd1} + {1'b0, rd2};

    always_ff @(posedge clk) begin
        if (reset) begin
            free1_valid <= 1'b0;
            free1_idx   <= '0;
            free2_valid <= 1'b0;
            free2_idx   <= '0;
            arch1_en    <= 1'b0;
            arch1_idx   <= '0;
            arch1_pdest <= '0;
            arch2_en    <= 1'b0;
            arch2_idx   <= '0;
            arch2_pdest <= '0;
            flush       <= 1'b0;
            redirect_pc <= '0;
            halted      <= 1'b0;
            retire_cnt  <= '0;
        end else begin
            arch1_en    <= rd1 && writes_arch(h1_wr, h1_ardest);
            arch1_idx   <= h1_ardest;
            arch1_pdest <= h1_pdest;
            free1_valid <= rd1 && writes_arch(h1_wr, h1_ardest);
            free1_idx   <= h1_pold;
            arch2_en    <= rd2 && writes_arch(h2_wr, h2_ardest);
            arch2_idx   <= h2_ardest;
            arch2_pdest <= h2_pdest;
            free2_valid <= rd2 && writes_arch(h2_wr, h2_ardest);
            free2_idx   <= h2_pold;
            // flush and halted mirror the state register one-for-one.
            flush       <= (state_nxt == FLUSH);
            halted      <= (state_nxt == HALT);
            retire_cnt  <= pop_cnt;
            if (redirect_load) redirect_pc <= redirect_nxt;
        end
    end

`ifdef RETIRE_STATS_EN
    logic [1:0] mispred_cnt;
    assign mispred_cnt = {1'b0, rd1 && h1_mispred} + {1'b0, rd2 && h2_mispred};

    retire_stats u_stats (
        .clk          (clk),
        .reset        (reset),
        .pop_cnt      (pop_cnt),
        .mispred_cnt  (mispred_cnt),
        .stat_retired (stat_retired),
        .stat_mispred (stat_mispred)
    );
`else
    assign stat_retired = '0;
    assign stat_mispred = '0;
`endif

endmodule

// File: doc/retire_unit.md
RETIRE_UNIT -- requirements
Module: retire_unit

Interface
REQ-001 SHALL have ports: clk input 1, rising-edge clock; reset input 1, synchronous, active-high.
REQ-002 SHALL have inputs hN_valid 1, hN_done 1, hN_wr 1, hN_ardest 5, hN_pdest PRF_IDX, hN_pold PRF_IDX, hN_mispred 1, hN_halt 1, hN_target 64, for N=1,2, describing the ROB head and head+1 entries.
REQ-003 SHALL have outputs rd1, rd2 1 each, combinational ROB pop requests.
REQ-004 SHALL have outputs freeN_valid 1 and freeN_idx PRF_IDX, registered, returning physical registers to the free list.
REQ-005 SHALL have outputs archN_en 1, archN_idx 5 and archN_pdest PRF_IDX, registered, writing the architectural map.
REQ-006 SHALL have outputs flush 1, redirect_pc 64, halted 1 and retire_cnt 2, all registered.
REQ-007 SHALL have outputs stat_retired 32 and stat_mispred 32, populated only per REQ-022.

Function
REQ-008 SHALL implement FSM states RUN, FLUSH and HALT.
REQ-009 In RUN, rd1 SHALL equal h1_valid & h1_done.
REQ-010 In RUN, rd2 SHALL equal rd1 & h2_valid & h2_done & ~h1_mispred & ~h1_halt.
- Retirement is strictly in order.
- Head+1 never retires past a mispredict or halt.
REQ-011 In FLUSH and HALT, rd1 and rd2 SHALL be 0.
REQ-012 For each retired slot with wr=1 and ardest!=ZERO_REG, the cycle after the pop SHALL assert:
- archN_en=1, archN_idx=ardest, archN_pdest=pdest;
- freeN_valid=1, freeN_idx=pold.
Otherwise archN_en=0 and freeN_valid=0.
REQ-013 Slot 1 outputs SHALL always correspond to the older instruction.
REQ-014 retire_cnt SHALL equal the number of pops in the previous cycle (0..2).
REQ-015 A retired instruction with mispred=1 SHALL cause, in the next cycle:
- flush=1 and redirect_pc=its target;
- state FLUSH.
REQ-016 FLUSH SHALL last exactly one cycle, then return to RUN.
REQ-017 flush SHALL be high only during FLUSH.
REQ-018 redirect_pc SHALL hold its last value when flush=0.
REQ-019 A retired instruction with halt=1 SHALL cause state HALT and halted=1 the next cycle.
- HALT is sticky until reset.
- If halt and mispred are both set, halt takes priority and no flush is issued.
REQ-020 Inputs with hN_valid=0 SHALL be ignored regardless of the other hN_* fields.
- h2_* alone never causes a pop.

Reset
REQ-021 When reset is high at a clock edge, the next state SHALL be:
- state RUN;
- all registered outputs 0, including redirect_pc and the stat counters;
- rd1 and rd2 forced to 0 while reset is high.
- A reset during FLUSH or HALT aborts it; no flush pulse follows.

Configuration
REQ-022 Macro RETIRE_STATS_EN SHALL control the statistics counters.
- Defined: stat_retired increments by the pop count each cycle; stat_mispred increments per retired mispredict. Both wrap modulo 2^32.
- Undefined: both outputs are constant 0 and no counter flops exist.

Structure
REQ-023 Shared package SHALL hold:
- PRF_IDX, ROB_IDX, ARF_IDX=5;
- ZERO_REG=31;
- the RETIRE_STATE enum {RUN, FLUSH, HALT}.
REQ-024 Counters SHALL be placed in one sub-module, retire_stats, instantiated only when RETIRE_STATS_EN is defined.

Verification
REQ-025 Dual retire: h1 {valid,done,wr,ardest=3,pdest=40,pold=7} and h2 {valid,done,wr,ardest=4,pdest=41,pold=9} -> rd1=rd2=1; next cycle arch1=(3,40), arch2=(4,41), free=7,9, retire_cnt=2.
REQ-026 Head not done: h1_done=0, h2 valid and done -> rd1=rd2=0, retire_cnt=0 next cycle.
REQ-027 Mispredict: h1_mispred=1, target=0x1000, h2 ready.
- Pop cycle: rd1=1, rd2=0.
- Next cycle: flush=1, redirect_pc=0x1000, rd1=rd2=0.
- Cycle after: RUN resumes.
REQ-028 Zero register: h1 wr=1, ardest=31 -> pop occurs, arch1_en=0, free1_valid=0, retire_cnt=1.
REQ-029 Halt: h1_halt=1 -> halted=1 next cycle; rd stays 0 for 10 cycles with ready heads; reset returns to RUN.
REQ-030 Stats (RETIRE_STATS_EN defined): 3 dual retires then 1 mispredict retire -> stat_retired=7, stat_mispred=1.
